fp_addsub_seq: RTL and testbench

- Sequencer in front of the single-precision IEEE754 add/sub datapath.
- Accepts one operand pair plus an op bit over a valid/ready handshake, then classifies both operands as Zero, Inf or NaN (exponent/fraction decode).
- Special-case combinations are resolved in the controller without using the datapath. All other pairs are launched into the fixed-latency datapath, and the result is captured after LAT cycles.
- The result is held on a valid/ready output port until the consumer takes it.

---
 rtl/fp_addsub_seq_if.sv | 41 ++++
 rtl/fp_addsub_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_addsub_seq_if.sv
// ---------------------------------------------------------------------------
// fp_addsub_seq_if
// Bundles every handshake and bus signal of the fp_addsub_seq controller.
//   Operand port : in_valid/in_ready handshake, in_a, in_b, in_op.
//   Datapath port: dp_start launch pulse, dp_a, dp_b, dp_op out;
//                  dp_result back from the fixed-latency adder.
//   Result port  : out_valid/out_ready handshake, out_result,
//                  out_special (bypass result), out_invalid (invalid op).
// Modports:
//   slave  - the controller (fp_addsub_seq) side.
//   master - the environment side (operand producer, datapath, consumer).
// ---------------------------------------------------------------------------
interface fp_addsub_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_op;
    logic        dp_start;
    logic [31:0] dp_a;
    logic [31:0] dp_b;
    logic        dp_op;
    logic [31:0] dp_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_special;
    logic        out_invalid;

    modport slave (
        input  in_valid, in_a, in_b, in_op, dp_result, out_ready,
        output in_ready, dp_start, dp_a, dp_b, dp_op,
               out_valid, out_result, out_special, out_invalid
    );

    modport master (
        output in_valid, in_a, in_b, in_op, dp_result, out_ready,
        input  in_ready, dp_start, dp_a, dp_b, dp_op,
               out_valid, out_result, out_special, out_invalid
    );
endinterface

// File: rtl/fp_addsub_seq.sv
// ---------------------------------------------------------------------------
// fp_addsub_seq
// Sequencer in front of a single-precision IEEE754 add/sub datapath.
// Accepts one operand pair + op, classifies both operands (Zero/Inf/NaN),
// resolves special combinations locally, otherwise launches the datapath
// and captures its result LAT cycles after the launch pulse. The result is
// held on the output handshake until the consumer takes it.
// Ports:
//   clk   - single clock, rising edge.
//   rst_n - asynchronous active-low reset.
//   bus   - fp_addsub_seq_if.slave (operand, datapath and result ports).
// Parameters:
//   LAT - datapath latency from dp_start to dp_result valid (1..15).
//   CW  - latency counter width, 2**CW > LAT.
// ---------------------------------------------------------------------------
module fp_addsub_seq #(
    parameter int LAT = 3,
    parameter int CW  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    fp_addsub_seq_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_HOLD = 2'b10
    } state_t;

    typedef struct packed {
        logic        special;
        logic        invalid;
        logic [31:0] result;
    } bypass_t;

    localparam logic [CW-1:0] LAT_LD   = CW'(LAT);
    localparam logic [31:0]   QNAN     = 32'h7FC0_0000;

    // Operand classification helpers (exponent 30:23, fraction 22:0).
    function automatic logic is_zero(input logic [31:0] x);
        return (x[30:23] == 8'h00) && (x[22:0] == 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Bypass resolution; the first matching rule wins. B's sign is taken
    // after the op bit flips it, so A-B is treated as A+(-B) throughout.
    function automatic bypass_t resolve(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic        op);
        bypass_t r;
        logic    sa;
        logic    sb_eff;
        sa     = a[31];
        sb_eff = b[31] ^ op;
        r      = '{special: 1'b1, invalid: 1'b0, result: 32'h0000_0000};
        if (is_nan(a) || is_nan(b)) begin
            r.result  = QNAN;
            r.invalid = 1'b1;
        end else if (is_inf(a) && is_inf(b) && (sa != sb_eff)) begin
            r.result  = QNAN;
            r.invalid = 1'b1;
        end else if (is_inf(a)) begin
            r.result = a;
        end else if (is_inf(b)) begin
            r.result = {sb_eff, 8'hFF, 23'd0};
        end else if (is_zero(a) && is_zero(b)) begin
            r.result = {sa & sb_eff, 31'd0};
        end else if (is_zero(a)) begin
            r.result = {sb_eff, b[30:0]};
        end else if (is_zero(b)) begin
            r.result = a;
        end else begin
            r.special = 1'b0;
        end
        return r;
    endfunction

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    bypass_t       w_bypass;
    logic          w_accept;
    logic          w_launch;
    logic          w_special_take;
    logic          w_capture;

    logic          r_dp_start;
    logic [31:0]   r_dp_a;
    logic [31:0]   r_dp_b;
    logic          r_dp_op;
    logic          r_out_valid;
    logic [31:0]   r_out_result;
    logic          r_out_special;
    logic          r_out_invalid;

    // Classify the operands presented on the input port.
    always_comb begin
        w_bypass = resolve(bus.in_a, bus.in_b, bus.in_op);
    end

    // Next-state, counter and launch/capture strobes.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_accept       = 1'b0;
        w_launch       = 1'b0;
        w_special_take = 1'b0;
        w_capture      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_accept = 1'b1;
                    if (w_bypass.special) begin
                        w_special_take = 1'b1;
                        w_state_nxt    = S_HOLD;
                    end else begin
                        w_launch    = 1'b1;
                        w_cnt_nxt   = LAT_LD;
                        w_state_nxt = S_BUSY;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUSY: begin
                // Counter is LAT in the dp_start cycle and reaches zero in
                // exactly the cycle the datapath presents its result.
                if (r_cnt == {CW{1'b0}}) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = {CW{1'b0}};
            end
        endcase
    end

    // State and latency counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= {CW{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Datapath launch registers; operands stay stable until the next launch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dp_start <= 1'b0;
            r_dp_a     <= 32'h0000_0000;
            r_dp_b     <= 32'h0000_0000;
            r_dp_op    <= 1'b0;
        end else begin
            r_dp_start <= w_launch;
            if (w_launch) begin
                r_dp_a  <= bus.in_a;
                r_dp_b  <= bus.in_b;
                r_dp_op <= bus.in_op;
            end else begin
                r_dp_a  <= r_dp_a;
                r_dp_b  <= r_dp_b;
                r_dp_op <= r_dp_op;
            end
        end
    end

    // Result registers, loaded from the bypass path or the datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_result  <= 32'h0000_0000;
            r_out_special <= 1'b0;
            r_out_invalid <= 1'b0;
        end else begin
            r_out_valid <= (w_state_nxt == S_HOLD);
            if (w_special_take) begin
                r_out_result  <= w_bypass.result;
                r_out_special <= 1'b1;
                r_out_invalid <= w_bypass.invalid;
            end else if (w_capture) begin
                r_out_result  <= bus.dp_result;
                r_out_special <= 1'b0;
                r_out_invalid <= 1'b0;
            end else begin
                r_out_result  <= r_out_result;
                r_out_special <= r_out_special;
                r_out_invalid <= r_out_invalid;
            end
        end
    end

    assign bus.in_ready    = (r_state == S_IDLE);
    assign bus.dp_start    = r_dp_start;
    assign bus.dp_a        = r_dp_a;
    assign bus.dp_b        = r_dp_b;
    assign bus.dp_op       = r_dp_op;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_result  = r_out_result;
    assign bus.out_special = r_out_special;
    assign bus.out_invalid = r_out_invalid;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// ---------------------------------------------------------------------------
// tb_fp_addsub_seq
// Directed self-checking bench for fp_addsub_seq with LAT=3. A small
// delay-line model stands in for the datapath: it returns the value the
// current test expects exactly LAT cycles after the dp_start cycle and
// garbage in every other cycle. Inputs change and outputs are sampled on
// the falling clock edge.
// ---------------------------------------------------------------------------
module tb_fp_addsub_seq;

    localparam int LAT = 3;

    logic        clk;
    logic        rst_n;
    logic [31:0] dp_model;
    logic [31:0] r_pipe [LAT];
    int          n_tests;
    int          n_fail;

    fp_addsub_seq_if bus();

    fp_addsub_seq #(.LAT(LAT), .CW(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stand-in: fixed-latency delay line of the expected result.
    always @(posedge clk) begin
        r_pipe[0] <= bus.dp_start ? dp_model : 32'hDEAD_BEEF;
        for (int i = 1; i < LAT; i++) begin
            r_pipe[i] <= r_pipe[i-1];
        end
    end
    assign bus.dp_result = r_pipe[LAT-1];

    // Hard stop in case anything stalls the sequence.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset.in_ready: got %b expected 1", bus.in_ready);
        end
        n_tests++;
        if ({bus.out_valid, bus.dp_start, bus.out_special, bus.out_invalid} !== 4'b0000) begin
            n_fail++; $display("FAIL reset.flags: got %b expected 0000",
                               {bus.out_valid, bus.dp_start, bus.out_special, bus.out_invalid});
        end
        n_tests++;
        if ({bus.out_result, bus.dp_a, bus.dp_b, bus.dp_op} !== 97'd0) begin
            n_fail++; $display("FAIL reset.data: got %h/%h/%h/%b expected zeros",
                               bus.out_result, bus.dp_a, bus.dp_b, bus.dp_op);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Normal-path op with out_ready high; DUT must be idle on entry.
    task automatic test_normal(input string name, input logic [31:0] a,
                               input logic [31:0] b, input logic op,
                               input logic [31:0] model);
        dp_model = model;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s.idle_ready: got %b expected 1", name, bus.in_ready);
        end
        bus.in_a = a; bus.in_b = b; bus.in_op = op; bus.in_valid = 1'b1;
        @(negedge clk);                       // cycle T+1
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.dp_start !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL %s.launch: got dp_start=%b in_ready=%b expected 1/0",
                               name, bus.dp_start, bus.in_ready);
        end
        n_tests++;
        if (bus.dp_a !== a || bus.dp_b !== b || bus.dp_op !== op) begin
            n_fail++; $display("FAIL %s.dp_operands: got %h %h %b expected %h %h %b",
                               name, bus.dp_a, bus.dp_b, bus.dp_op, a, b, op);
        end
        for (int k = 2; k <= LAT + 1; k++) begin
            @(negedge clk);
            n_tests++;
            if (bus.dp_start !== 1'b0 || bus.out_valid !== 1'b0) begin
                n_fail++; $display("FAIL %s.busy_c%0d: got dp_start=%b out_valid=%b expected 0/0",
                                   name, k, bus.dp_start, bus.out_valid);
            end
        end
        @(negedge clk);                       // cycle T+LAT+2
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== model) begin
            n_fail++; $display("FAIL %s.result: got valid=%b %h expected 1 %h",
                               name, bus.out_valid, bus.out_result, model);
        end
        n_tests++;
        if (bus.out_special !== 1'b0 || bus.out_invalid !== 1'b0) begin
            n_fail++; $display("FAIL %s.result_flags: got special=%b invalid=%b expected 0/0",
                               name, bus.out_special, bus.out_invalid);
        end
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s.release: got valid=%b in_ready=%b expected 0/1",
                               name, bus.out_valid, bus.in_ready);
        end
    endtask

    // Bypass-path op with out_ready high; DUT must be idle on entry.
    task automatic test_special(input string name, input logic [31:0] a,
                                input logic [31:0] b, input logic op,
                                input logic [31:0] exp_res, input logic exp_inv);
        bus.in_a = a; bus.in_b = b; bus.in_op = op; bus.in_valid = 1'b1;
        @(negedge clk);                       // cycle T+1
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== exp_res) begin
            n_fail++; $display("FAIL %s.result: got valid=%b %h expected 1 %h",
                               name, bus.out_valid, bus.out_result, exp_res);
        end
        n_tests++;
        if (bus.out_special !== 1'b1 || bus.out_invalid !== exp_inv || bus.dp_start !== 1'b0) begin
            n_fail++; $display("FAIL %s.flags: got special=%b invalid=%b dp_start=%b expected 1/%b/0",
                               name, bus.out_special, bus.out_invalid, bus.dp_start, exp_inv);
        end
        @(negedge clk);                       // cycle T+2
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s.release: got valid=%b in_ready=%b expected 0/1",
                               name, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_bypass_rules();
        test_special("inf_minus_inf", 32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 1'b1);
        test_special("nzero_minus_zero", 32'h8000_0000, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0);
        test_special("zero_minus_one", 32'h0000_0000, 32'h3F80_0000, 1'b1, 32'hBF80_0000, 1'b0);
        test_special("nan_a", 32'h7F80_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 1'b1);
        test_special("nan_b", 32'h3F80_0000, 32'hFFC0_0001, 1'b0, 32'h7FC0_0000, 1'b1);
        test_special("inf_plus_inf", 32'h7F80_0000, 32'h7F80_0000, 1'b0, 32'h7F80_0000, 1'b0);
        test_special("inf_minus_ninf", 32'h7F80_0000, 32'hFF80_0000, 1'b1, 32'h7F80_0000, 1'b0);
        test_special("one_minus_inf", 32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000, 1'b0);
        test_special("b_zero", 32'h4049_0FDB, 32'h8000_0000, 1'b0, 32'h4049_0FDB, 1'b0);
        test_special("zero_plus_zero", 32'h8000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0);
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        dp_model = 32'h4000_0000;
        bus.in_a = 32'h4040_0000; bus.in_b = 32'h3F80_0000; bus.in_op = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);                       // cycle T+1, hold a new operand
        bus.in_a = 32'h0000_0000; bus.in_b = 32'h3F80_0000; bus.in_op = 1'b0;
        for (int k = 2; k <= LAT + 2; k++) begin
            @(negedge clk);
        end
        for (int h = 0; h < 5; h++) begin
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h4000_0000 ||
                bus.out_special !== 1'b0 || bus.out_invalid !== 1'b0) begin
                n_fail++; $display("FAIL bp.hold%0d: got valid=%b %h s=%b i=%b expected 1 40000000 0 0",
                                   h, bus.out_valid, bus.out_result, bus.out_special, bus.out_invalid);
            end
            n_tests++;
            if (bus.in_ready !== 1'b0 || bus.dp_start !== 1'b0 || bus.dp_a !== 32'h4040_0000) begin
                n_fail++; $display("FAIL bp.blocked%0d: got in_ready=%b dp_start=%b dp_a=%h expected 0 0 40400000",
                                   h, bus.in_ready, bus.dp_start, bus.dp_a);
            end
            if (h == 4) bus.out_ready = 1'b1;
            else        bus.out_ready = 1'b0;
            @(negedge clk);
        end
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp.released: got in_ready=%b valid=%b expected 1/0",
                               bus.in_ready, bus.out_valid);
        end
        @(negedge clk);                       // held operand taken at previous edge
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h3F80_0000 || bus.out_special !== 1'b1) begin
            n_fail++; $display("FAIL bp.held_op: got valid=%b %h s=%b expected 1 3f800000 1",
                               bus.out_valid, bus.out_result, bus.out_special);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_in_busy();
        int seen;
        dp_model = 32'h4040_0000;
        bus.in_a = 32'h3F80_0000; bus.in_b = 32'h4000_0000; bus.in_op = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);                       // T+1
        bus.in_valid = 1'b0;
        @(negedge clk);                       // T+2
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.dp_start !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_busy.ctrl: got in_ready=%b dp_start=%b valid=%b expected 1 0 0",
                               bus.in_ready, bus.dp_start, bus.out_valid);
        end
        n_tests++;
        if (bus.dp_a !== 32'd0 || bus.dp_b !== 32'd0 || bus.out_result !== 32'd0) begin
            n_fail++; $display("FAIL rst_busy.data: got %h %h %h expected zeros",
                               bus.dp_a, bus.dp_b, bus.out_result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.dp_start !== 1'b0) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++; $display("FAIL rst_busy.aborted: got %0d active cycles expected 0", seen);
        end
        test_normal("after_reset", 32'h4000_0000, 32'h4000_0000, 1'b0, 32'h4080_0000);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        dp_model = 32'h0000_0000;
        bus.in_valid = 1'b0;
        bus.in_a = 32'h0000_0000;
        bus.in_b = 32'h0000_0000;
        bus.in_op = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_normal("one_plus_two", 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000);
        test_bypass_rules();
        test_normal("denormal", 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002);
        test_normal("sub_normal", 32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000);
        test_backpressure();
        test_reset_in_busy();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
